// File: rtl/logicnet_pipe_pkg.sv
// Shared types and default widths for LogicNet layer-boundary pipeline stages.
package logicnet_pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;

  localparam int unsigned DEFAULT_LAYER_WIDTH = 1024;
  localparam int unsigned DEFAULT_CNT_WIDTH   = 32;

endpackage

// File: rtl/logicnet_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module logicnet_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/logicnet_layer_skid_buf.sv
// Two-entry skid buffer between LogicNet layers; handshake outputs decode from state flops only.
// Optional stall counter enabled by LOGICNET_SKID_STALL_CNT_EN.
module logicnet_layer_skid_buf
  import logicnet_pipe_pkg::*;
#(
  parameter int unsigned LAYER_WIDTH = DEFAULT_LAYER_WIDTH
`ifdef LOGICNET_SKID_STALL_CNT_EN
  , parameter int unsigned CNT_WIDTH = DEFAULT_CNT_WIDTH
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LAYER_WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LAYER_WIDTH-1:0] out_data
`ifdef LOGICNET_SKID_STALL_CNT_EN
  , output logic [CNT_WIDTH-1:0] stall_cnt
  , input  logic                 stall_clr
`endif
);

  skid_state_t            state_q, state_d;
  logic [LAYER_WIDTH-1:0] head_q,  head_d;
  logic [LAYER_WIDTH-1:0] skid_q,  skid_d;
  logic                   push, pop;

  assign in_ready  = (state_q != SKID_FULL);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = head_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Storage only loads on push (or skid->head on pop), so idle in_data never reaches the flops.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          head_d  = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (pop) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef LOGICNET_SKID_STALL_CNT_EN
  logicnet_sat_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (out_valid & ~out_ready),
    .clr  (stall_clr),
    .cnt  (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_logicnet_layer_skid_buf.sv
// Directed + randomized bench for logicnet_layer_skid_buf against a queue-based FIFO model.
module tb_logicnet_layer_skid_buf;

  localparam int unsigned LW = 1024;
`ifdef LOGICNET_SKID_STALL_CNT_EN
  localparam int unsigned CW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [LW-1:0] in_data, out_data;
`ifdef LOGICNET_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
  logic          stall_clr;
  int unsigned   sc_exp;
`endif
  logic          sat_inc, sat_clr;
  logic [2:0]    sat_cnt;

  always #5 clk = ~clk;

  logicnet_layer_skid_buf #(
    .LAYER_WIDTH(LW)
`ifdef LOGICNET_SKID_STALL_CNT_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef LOGICNET_SKID_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
    , .stall_clr(stall_clr)
`endif
  );

  logicnet_sat_counter #(.CNT_WIDTH(3)) u_sat (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (sat_inc),
    .clr  (sat_clr),
    .cnt  (sat_cnt)
  );

  int unsigned   n_chk  = 0;
  int unsigned   n_pass = 0;
  logic [LW-1:0] fifo_q[$];
  logic [LW-1:0] shown;

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic chkd(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed[127:0]=%h expected[127:0]=%h", tag, obs[127:0], exp[127:0]);
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: check outputs mid-cycle, probe out_ready->in_ready independence, advance the model.
  task automatic step(input bit probe);
    logic r0, push, pop;
    @(negedge clk);
    chk1("in_ready", in_ready, fifo_q.size() < 2);
    chk1("out_valid", out_valid, fifo_q.size() > 0);
    chkd("out_data", out_data, shown);
`ifdef LOGICNET_SKID_STALL_CNT_EN
    chkn("stall_cnt", 32'(stall_cnt), sc_exp);
`endif
    if (probe) begin
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      chk1("in_ready_comb", in_ready, r0);
      out_ready = ~out_ready;
      #1;
    end
    push = in_valid && (fifo_q.size() < 2);
    pop  = out_ready && (fifo_q.size() > 0);
`ifdef LOGICNET_SKID_STALL_CNT_EN
    if (stall_clr) sc_exp = 0;
    else if (fifo_q.size() > 0 && !out_ready && sc_exp < (1 << CW) - 1) sc_exp++;
`endif
    @(posedge clk);
    if (pop) void'(fifo_q.pop_front());
    if (push) fifo_q.push_back(in_data);
    if (fifo_q.size() > 0) shown = fifo_q[0];
    #1;
  endtask

  initial begin : main
    logic [LW-1:0] va, vb;
    int unsigned   sat_exp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    sat_inc = 1'b0; sat_clr = 1'b0;
`ifdef LOGICNET_SKID_STALL_CNT_EN
    stall_clr = 1'b0; sc_exp = 0;
`endif
    shown = '0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkd("rst_out_data", out_data, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Streaming: 100 vectors back to back.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = rand_vec();
      step(1'b0);
      chkd("stream_latency", out_data, in_data);
      chk1("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step(1'b0); step(1'b0);

    // Backpressure: A then B with out_ready low.
    va = rand_vec(); vb = rand_vec();
    out_ready = 1'b0; in_valid = 1'b1; in_data = va;
    step(1'b0);
    in_data = vb;
    step(1'b0);
    in_valid = 1'b0; in_data = 'x;
    chk1("bp_full_in_ready", in_ready, 1'b0);
    chk1("bp_full_out_valid", out_valid, 1'b1);
    chkd("bp_head_a", out_data, va);
    in_valid = 1'b1; in_data = rand_vec();
    step(1'b1); step(1'b0);
    chkd("bp_a_stable", out_data, va);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(1'b0);
    chkd("bp_then_b", out_data, vb);
    chk1("bp_ready_back", in_ready, 1'b1);
    step(1'b0);
    chk1("bp_drained", out_valid, 1'b0);

    // Simultaneous push/pop in ONE.
    in_valid = 1'b1; out_ready = 1'b0; in_data = {(LW/8){8'hAA}};
    step(1'b0);
    out_ready = 1'b1; in_data = {(LW/8){8'h55}};
    step(1'b0);
    chkd("pushpop_data", out_data, {(LW/8){8'h55}});
    chk1("pushpop_one_valid", out_valid, 1'b1);
    chk1("pushpop_one_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    step(1'b0);

    // Random valid/ready with idle in_data left unknown.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_data   = in_valid ? rand_vec() : 'x;
`ifdef LOGICNET_SKID_STALL_CNT_EN
      stall_clr = ($urandom_range(15) == 0);
`endif
      step((i % 8) == 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
`ifdef LOGICNET_SKID_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    step(1'b0); step(1'b0);

`ifdef LOGICNET_SKID_STALL_CNT_EN
    // Stall counter: clear, stall 7 cycles, clear, then saturate.
    stall_clr = 1'b1; step(1'b0); stall_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; in_data = rand_vec();
    step(1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step(1'b0);
    chkn("stall_7", 32'(stall_cnt), 32'd7);
    stall_clr = 1'b1; step(1'b0); stall_clr = 1'b0;
    chkn("stall_clr", 32'(stall_cnt), 32'd0);
    for (int i = 0; i < 300; i++) step(1'b0);
    chkn("stall_sat", 32'(stall_cnt), (32'd1 << CW) - 32'd1);
    out_ready = 1'b1;
    step(1'b0); step(1'b0);
`endif

    // Reset mid-stream with two vectors held.
    in_valid = 1'b1; out_ready = 1'b0;
    in_data = rand_vec(); step(1'b0);
    in_data = rand_vec(); step(1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    chkd("midrst_out_data", out_data, '0);
    fifo_q.delete(); shown = '0;
`ifdef LOGICNET_SKID_STALL_CNT_EN
    sc_exp = 0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'($urandom);
      in_data  = rand_vec();
      step(1'b0);
    end
    in_valid = 1'b0;
    step(1'b0); step(1'b0);

    // Standalone 3-bit saturating counter.
    sat_clr = 1'b1; @(posedge clk); #1; sat_clr = 1'b0;
    chkn("sat_clr0", 32'(sat_cnt), 32'd0);
    sat_exp = 0; sat_inc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (sat_exp < 7) sat_exp++;
      chkn("sat_inc", 32'(sat_cnt), sat_exp);
    end
    sat_clr = 1'b1;
    @(posedge clk); #1;
    chkn("sat_clr_prio", 32'(sat_cnt), 32'd0);
    sat_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    chkn("sat_3", 32'(sat_cnt), 32'd3);
    sat_inc = 1'b0;
    @(posedge clk); #1;
    chkn("sat_hold", 32'(sat_cnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
